// File: rtl/pipeline_result_fifo.sv
// FWFT result buffer behind stallable_pipeline.
// Decouples a slow consumer from the pipeline's out_allow.
module pipeline_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     validin,
    input  logic [WIDTH-1:0]         datain,
    output logic                     in_allow,
    output logic                     validout,
    output logic [WIDTH-1:0]         dataout,
    input  logic                     out_allow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // in_allow comes from registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_allow = (r_count != FULL);
    assign validout = (r_count != '0);
    assign dataout  = validout ? r_mem[r_rd_ptr] : '0;
    assign count    = r_count;

    assign w_push = validin && in_allow;
    assign w_pop  = validout && out_allow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Directed bench for pipeline_result_fifo (WIDTH=8, DEPTH=4).
// Each task drives one scenario and checks outputs 1 ns after the edge.
module tb_pipeline_result_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       validin = 1'b0;
    logic [7:0] datain = 8'h00;
    logic       in_allow;
    logic       validout;
    logic [7:0] dataout;
    logic       out_allow = 1'b0;
    logic [2:0] count;

    int n_pass = 0;
    int n_total = 0;

    pipeline_result_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .validin(validin),
        .datain(datain),
        .in_allow(in_allow),
        .validout(validout),
        .dataout(dataout),
        .out_allow(out_allow),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        validin = 1'b1;
        datain = 8'h77;
        out_allow = 1'b0;
        tick();
        tick();
        n_total++;
        if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count);
        else n_pass++;
        n_total++;
        if (validout !== 1'b0) $display("FAIL rst_validout got %b want 0", validout);
        else n_pass++;
        n_total++;
        if (in_allow !== 1'b1) $display("FAIL rst_in_allow got %b want 1", in_allow);
        else n_pass++;
        n_total++;
        if (dataout !== 8'h00) $display("FAIL rst_dataout got %h want 00", dataout);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_total++;
        if (count !== 3'd1) $display("FAIL rst_first_push_count got %0d want 1", count);
        else n_pass++;
        n_total++;
        if (dataout !== 8'h77) $display("FAIL rst_first_push_data got %h want 77", dataout);
        else n_pass++;
        validin = 1'b0;
        out_allow = 1'b1;
        tick();
        n_total++;
        if (validout !== 1'b0) $display("FAIL rst_drain_validout got %b want 0", validout);
        else n_pass++;
    endtask

    task automatic test_pass_through();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        out_allow = 1'b1;
        validin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datain = vals[i];
            tick();
            n_total++;
            if (dataout !== vals[i] || validout !== 1'b1)
                $display("FAIL pass_data%0d got %h/%b want %h/1", i, dataout, validout, vals[i]);
            else n_pass++;
            n_total++;
            if (count !== 3'd1) $display("FAIL pass_count%0d got %0d want 1", i, count);
            else n_pass++;
        end
        validin = 1'b0;
        tick();
        n_total++;
        if (validout !== 1'b0 || count !== 3'd0)
            $display("FAIL pass_empty got %b/%0d want 0/0", validout, count);
        else n_pass++;
    endtask

    task automatic test_fill_stall();
        out_allow = 1'b0;
        validin = 1'b1;
        for (int i = 0; i < 6; i++) begin
            datain = 8'hA0 + 8'(i);
            tick();
            if (i == 3) begin
                n_total++;
                if (in_allow !== 1'b0) $display("FAIL fill_in_allow got %b want 0", in_allow);
                else n_pass++;
            end
        end
        n_total++;
        if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count);
        else n_pass++;
        validin = 1'b0;
        out_allow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (dataout !== 8'hA0 + 8'(i) || validout !== 1'b1)
                $display("FAIL fill_drain%0d got %h/%b want %h/1", i, dataout, validout, 8'hA0 + 8'(i));
            else n_pass++;
            tick();
        end
        n_total++;
        if (validout !== 1'b0 || count !== 3'd0)
            $display("FAIL fill_empty got %b/%0d want 0/0", validout, count);
        else n_pass++;
    endtask

    task automatic test_full_simul();
        logic [7:0] exp [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        out_allow = 1'b0;
        validin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            datain = 8'hB0 + 8'(i);
            tick();
        end
        datain = 8'hC0;
        out_allow = 1'b1;
        tick();
        n_total++;
        if (count !== 3'd3 || dataout !== 8'hB1)
            $display("FAIL full_simul_pop got %0d/%h want 3/b1", count, dataout);
        else n_pass++;
        out_allow = 1'b0;
        tick();
        n_total++;
        if (count !== 3'd4) $display("FAIL full_simul_push got %0d want 4", count);
        else n_pass++;
        validin = 1'b0;
        out_allow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (dataout !== exp[i])
                $display("FAIL full_simul_drain%0d got %h want %h", i, dataout, exp[i]);
            else n_pass++;
            tick();
        end
        n_total++;
        if (validout !== 1'b0) $display("FAIL full_simul_empty got %b want 0", validout);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int m_cnt = 0;
        int next = 1;
        int popped = 0;
        int errs = 0;
        bit m_push;
        bit m_pop;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            validin = (next <= 10);
            datain = 8'(next);
            out_allow = cyc[0];
            m_push = validin && (m_cnt != 4);
            m_pop = out_allow && (m_cnt != 0);
            if (m_pop) begin
                void'(q.pop_front());
                popped++;
            end
            if (m_push) begin
                q.push_back(datain);
                next++;
            end
            m_cnt = m_cnt + int'(m_push) - int'(m_pop);
            tick();
            if (count !== 3'(m_cnt)) begin
                errs++;
                $display("FAIL wrap_count c%0d got %0d want %0d", cyc, count, m_cnt);
            end
            if (m_cnt != 0 && dataout !== q[0]) begin
                errs++;
                $display("FAIL wrap_data c%0d got %h want %h", cyc, dataout, q[0]);
            end
        end
        validin = 1'b0;
        n_total++;
        if (errs != 0) $display("FAIL wrap_order got %0d errors want 0", errs);
        else n_pass++;
        n_total++;
        if (popped != 10) $display("FAIL wrap_timeout got %0d pops want 10", popped);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_allow = 1'b0;
        validin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datain = 8'h61 + 8'(i);
            tick();
        end
        n_total++;
        if (count !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", count);
        else n_pass++;
        validin = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if (validout !== 1'b0 || count !== 3'd0)
            $display("FAIL mid_async got %b/%0d want 0/0", validout, count);
        else n_pass++;
        #2;
        rst = 1'b1;
        validin = 1'b1;
        datain = 8'h5A;
        tick();
        n_total++;
        if (dataout !== 8'h5A || count !== 3'd1)
            $display("FAIL mid_push got %h/%0d want 5a/1", dataout, count);
        else n_pass++;
        validin = 1'b0;
        out_allow = 1'b1;
        tick();
        n_total++;
        if (validout !== 1'b0) $display("FAIL mid_stale got %b want 0", validout);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
